// File: rtl/if_id_skid_buffer.sv
// Two-entry IF/ID skid buffer: pushed pair visible right after its edge when empty;
// in_ready comes from registered occupancy only, so decode's ready never reaches fetch combinationally.
module if_id_skid_buffer #(
  parameter logic [31:0] PC_RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR     = 32'h0000_0013,
  parameter int          DROP_CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  JumpFlag,
  input  logic                  in_valid,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_instr,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_instr,
  input  logic                  out_ready,
  output logic [1:0]            count,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  if_id_t                entry [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  push;
  logic                  pop;
  logic [DROP_CNT_W:0]   drop_sum;

  assign in_ready  = (count != 2'd2);
  // A redirect kills the presented pair too, so decode never sees a wrong-path instruction.
  assign out_valid = (count != 2'd0) && !JumpFlag;
  assign push      = in_valid && in_ready && !JumpFlag;
  assign pop       = out_valid && out_ready;

  assign out_pc    = (count == 2'd0) ? PC_RESET_ADDR : entry[rd_ptr].pc;
  assign out_instr = (count == 2'd0) ? NOP_INSTR     : entry[rd_ptr].instr;

  // One extra bit catches overflow so the counter can clamp at all-ones.
  assign drop_sum  = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      drop_cnt <= '0;
      entry[0] <= {PC_RESET_ADDR, NOP_INSTR};
      entry[1] <= {PC_RESET_ADDR, NOP_INSTR};
    end else if (JumpFlag) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end else begin
      if (push) begin
        entry[wr_ptr] <= {in_pc, in_instr};
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
